gold_output_arbiter: RTL

GOLD_OUTPUT_ARBITER -- requirements
Module: gold_output_arbiter

---
 rtl/gold_output_arbiter_if.sv | 7 +
 rtl/gold_output_arbiter.sv | 40 ++++
 2 files changed

// File: rtl/gold_output_arbiter_if.sv
// gold_output_arbiter_if: ring/PE requester ports and output link of the arbiter
interface gold_output_arbiter_if #(parameter int PACKET_SIZE = 64);
    logic polarity, rsi, rri, psi, pri, so, ro;
    logic [PACKET_SIZE-1:0] rd, pd, dout;
    modport master(output polarity, rsi, rd, psi, pd, ro, input rri, pri, so, dout);
    modport slave(input polarity, rsi, rd, psi, pd, ro, output rri, pri, so, dout);
endinterface

// File: rtl/gold_output_arbiter.sv
// gold_output_arbiter: two one-entry VC buffers fed by ring/PE requesters with per-VC round-robin
module gold_output_arbiter #(parameter int PACKET_SIZE = 64) (
    input logic clk,
    input logic reset,
    gold_output_arbiter_if.slave bus
);
    logic [1:0] valid, ptr, rreq, preq, rg, pg;
    logic [PACKET_SIZE-1:0] data [2];
    logic drain;
    genvar v;
    for (v = 0; v < 2; v++) begin : g_vc
        assign rreq[v] = bus.rsi && (bus.rd[PACKET_SIZE-1] == 1'(v));
        assign preq[v] = bus.psi && (bus.pd[PACKET_SIZE-1] == 1'(v));
        // a buffer only accepts when empty at cycle start; ptr breaks ties
        assign rg[v] = reset && !valid[v] && rreq[v] && (!preq[v] || !ptr[v]);
        assign pg[v] = reset && !valid[v] && preq[v] && (!rreq[v] || ptr[v]);
    end
    assign bus.rri = |rg;
    assign bus.pri = |pg;
    assign bus.so = reset && valid[bus.polarity];
    assign bus.dout = data[bus.polarity];
    assign drain = bus.so && bus.ro;
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
            ptr <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rg[i] || pg[i]) begin
                    valid[i] <= 1'b1;
                    data[i] <= rg[i] ? bus.rd : bus.pd;
                end else if (drain && bus.polarity == 1'(i)) begin
                    valid[i] <= 1'b0;
                end
                // contested grant: pointer moves to the loser
                if (rreq[i] && preq[i] && !valid[i]) ptr[i] <= rg[i];
            end
        end
    end
endmodule
